// File: rtl/alu_result_fifo_pkg.sv
// Shared defaults and helpers for the ALU result FIFO slice.
package alu_result_fifo_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int LAT_DEF    = 2;
    localparam int DEPTH_DEF  = 4;

    localparam logic [7:0] DROP_SAT = 8'd255;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == DROP_SAT) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/alu_tag_pipe.sv
// LAT-stage single-bit delay line tracking which ALU cycles carry a result.
module alu_tag_pipe #(
    parameter int LAT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic din,
    output logic dout
);

    logic [LAT-1:0] sr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr <= '0;
        end else if (clr) begin
            sr <= '0;
        end else begin
            sr[0] <= din;
            for (int unsigned i = 1; i < LAT; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    assign dout = sr[LAT-1];

endmodule

// File: rtl/alu_result_fifo.sv
// Captures ALU results LAT cycles after issue into a small flop-based FIFO,
// counting results dropped because the FIFO was full.
module alu_result_fifo
    import alu_result_fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int LAT    = LAT_DEF
) (
    input  logic                     clk_p_i,
    input  logic                     reset_p_i,
    input  logic                     issue_i,
    input  logic [DATA_W-1:0]        data_i,
    input  logic                     flush_i,
    input  logic                     rdy_i,
    output logic                     vld_o,
    output logic [DATA_W-1:0]        data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic                     ovf_o,
    output logic [7:0]               drop_cnt_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              ovf;
    logic [7:0]        drop_cnt;

    logic push_req;
    logic full;
    logic empty;
    logic pop;
    logic push_ok;
    logic drop;

    alu_tag_pipe #(
        .LAT (LAT)
    ) u_tag_pipe (
        .clk  (clk_p_i),
        .rst  (reset_p_i),
        .clr  (flush_i),
        .din  (issue_i),
        .dout (push_req)
    );

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // A pop frees the head slot on the same edge, so a full FIFO can still accept.
    always_comb begin
        pop     = 1'b0;
        push_ok = 1'b0;
        drop    = 1'b0;
        if (!flush_i) begin
            pop     = !empty && rdy_i;
            push_ok = push_req && (!full || pop);
            drop    = push_req && full && !pop;
        end
    end

    always_ff @(posedge clk_p_i or posedge reset_p_i) begin
        if (reset_p_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ovf      <= 1'b0;
            drop_cnt <= '0;
        end else if (flush_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ovf      <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= data_i;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({push_ok, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (drop) begin
                ovf      <= 1'b1;
                drop_cnt <= sat_inc(drop_cnt);
            end
        end
    end

    assign vld_o      = !empty;
    assign data_o     = empty ? '0 : mem[rd_ptr];
    assign count_o    = count;
    assign full_o     = full;
    assign empty_o    = empty;
    assign ovf_o      = ovf;
    assign drop_cnt_o = drop_cnt;

endmodule
